// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : RV32I multi-cycle control FSM (fetch/decode/exec/mem/wb)
// Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       imm_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       wb_sel,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R     = 4'd0,
    C_IMM   = 4'd1,
    C_LD    = 4'd2,
    C_ST    = 4'd3,
    C_BR    = 4'd4,
    C_LUI   = 4'd5,
    C_AUIPC = 4'd6,
    C_JAL   = 4'd7,
    C_JALR  = 4'd8
  } cls_t;

  state_t          state, state_nxt;
  cls_t            cls, cls_nxt;
  cls_t            dec_cls;
  logic            dec_ok;
  logic            taken, taken_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic [CNT_W-1:0] instret_r, instret_nxt;
  logic            trap_r, trap_nxt;
  logic [1:0]      cause_r, cause_nxt;

  always_comb begin
    dec_cls = C_R;
    dec_ok  = 1'b1;
    case (op)
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b1100011: dec_cls = C_BR;
      7'b0000011: dec_cls = C_LD;
      7'b0100011: dec_cls = C_ST;
      7'b0010011: dec_cls = C_IMM;
      7'b0110011: dec_cls = C_R;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      cls       <= C_R;
      taken     <= 1'b0;
      tcnt      <= '0;
      instret_r <= '0;
      trap_r    <= 1'b0;
      cause_r   <= 2'd0;
    end else begin
      state     <= state_nxt;
      cls       <= cls_nxt;
      taken     <= taken_nxt;
      tcnt      <= tcnt_nxt;
      instret_r <= instret_nxt;
      trap_r    <= trap_nxt;
      cause_r   <= cause_nxt;
    end
  end

  // The wait counter is zeroed on every state change, so it always starts
  // from 0 on entry to FETCH or MEM; ready is checked before the limit.
  always_comb begin
    state_nxt   = state;
    cls_nxt     = cls;
    taken_nxt   = taken;
    tcnt_nxt    = tcnt;
    instret_nxt = instret_r;
    trap_nxt    = trap_r;
    cause_nxt   = cause_r;
    case (state)
      S_FETCH: begin
        if (imem_ready) begin
          state_nxt = S_DECODE;
          tcnt_nxt  = '0;
        end else if (tcnt == TLAST) begin
          state_nxt = S_HALT;
          trap_nxt  = 1'b1;
          cause_nxt = 2'd2;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          cls_nxt   = dec_cls;
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_HALT;
          trap_nxt  = 1'b1;
          cause_nxt = 2'd1;
        end
      end
      S_EXEC: begin
        if (cls == C_BR) taken_nxt = branch_taken;
        state_nxt = (cls == C_LD || cls == C_ST) ? S_MEM : S_WB;
        tcnt_nxt  = '0;
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_nxt = S_WB;
          tcnt_nxt  = '0;
        end else if (tcnt == TLAST) begin
          state_nxt = S_HALT;
          trap_nxt  = 1'b1;
          cause_nxt = 2'd3;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      S_WB: begin
        instret_nxt = instret_r + 1'b1;
        state_nxt   = S_FETCH;
        tcnt_nxt    = '0;
      end
      S_HALT: state_nxt = S_HALT;
      default: begin
        state_nxt = S_FETCH;
        tcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    imm_sel   = 3'd0;
    alu_a_sel = 2'd0;
    alu_b_sel = 1'b0;
    wb_sel    = 2'd0;
    // Operand selects hold from EXEC through WB so address/target stay stable.
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      case (cls)
        C_IMM, C_LD, C_JALR: begin imm_sel = 3'd1; alu_b_sel = 1'b1; end
        C_ST:    begin imm_sel = 3'd2; alu_b_sel = 1'b1; end
        C_BR:    begin imm_sel = 3'd3; alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
        C_LUI:   begin imm_sel = 3'd4; alu_a_sel = 2'd2; alu_b_sel = 1'b1; end
        C_AUIPC: begin imm_sel = 3'd4; alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
        C_JAL:   begin imm_sel = 3'd5; alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
        default: ;
      endcase
    end
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_ST);
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = (cls != C_BR) && (cls != C_ST);
        case (cls)
          C_LD:          wb_sel = 2'd1;
          C_JAL, C_JALR: wb_sel = 2'd2;
          default:       wb_sel = 2'd0;
        endcase
        case (cls)
          C_JAL:   pc_sel = 2'd1;
          C_JALR:  pc_sel = 2'd2;
          C_BR:    pc_sel = taken ? 2'd1 : 2'd0;
          default: pc_sel = 2'd0;
        endcase
      end
      default: ;
    endcase
    // The state register resets to FETCH; mask strobes while reset is held.
    if (!rst_n) begin
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      imm_sel   = 3'd0;
      alu_a_sel = 2'd0;
      alu_b_sel = 1'b0;
      wb_sel    = 2'd0;
    end
  end

  assign instret    = instret_r;
  assign trap       = trap_r;
  assign trap_cause = cause_r;

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM that sequences the RV32I datapath over multiple cycles: fetch, decode, execute, memory, writeback. It is the step from the single-cycle core toward a multi-cycle core. It owns the instruction/data memory handshakes, the register-file and PC write strobes, and the datapath mux selects, including the immediate-format select that drives the immediate generator. It also keeps a retired-instruction counter and traps on illegal opcodes or memory timeouts.

Parameters:
TIMEOUT, 16, maximum number of cycles a memory request may wait for ready before trapping (must be ≥1).
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  opcode of the latched instruction register (IR[6:0])
branch_taken  in  1  branch comparator result, valid in EXEC
imem_ready  in  1  instruction memory ready; completes a fetch when sampled with imem_req
dmem_ready  in  1  data memory ready; completes an access when sampled with dmem_req
imem_req  out  1  fetch request
ir_we  out  1  instruction register write strobe
dmem_req  out  1  data access request
dmem_we  out  1  data access is a store
rf_we  out  1  register file write strobe
pc_we  out  1  PC write strobe
pc_sel  out  2  next PC select: 0 = pc+4, 1 = pc+imm, 2 = (rs1+imm)&~1
imm_sel  out  3  immediate format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
alu_a_sel  out  2  ALU A operand: 0 rs1, 1 pc, 2 zero
alu_b_sel  out  1  ALU B operand: 0 rs2, 1 imm
wb_sel  out  2  writeback source: 0 alu, 1 mem, 2 pc+4
instret  out  CNT_W  retired-instruction count
trap  out  1  sticky halt indication
trap_cause  out  2  trap cause: 0 none, 1 illegal op, 2 imem timeout, 3 dmem timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. State is encoded in registers; outputs are a combinational decode of state, a latched copy of the instruction class, and the ready inputs.
- Reset (rst_n low, asynchronous):
  - State goes to FETCH; instret, trap, trap_cause and the timeout counter clear to 0.
  - Every strobe and select output is forced to 0 while rst_n is low.
  - Reset mid-instruction abandons the instruction with no writes.
- FETCH:
  - imem_req = 1.
  - ir_we = imem_req & imem_ready. That cycle advances to DECODE.
- DECODE:
  - Classify op and latch the class: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BR 1100011, LD 0000011, ST 0100011, IMM 0010011, R 0110011.
  - Any other op goes to HALT with trap_cause = 1.
- EXEC: selects are driven per class:
  - R: a = 0, b = 0, imm = 0
  - IMM / LD / JALR: a = 0, b = 1, imm = I
  - ST: a = 0, b = 1, imm = S
  - BR: a = 1, b = 1, imm = B
  - LUI: a = 2, b = 1, imm = U
  - AUIPC: a = 1, b = 1, imm = U
  - JAL: a = 1, b = 1, imm = J
  - BR samples branch_taken into a register.
  - LD and ST go to MEM; all other classes go to WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for ST.
  - Advances to WB on the cycle dmem_req & dmem_ready.
- WB: single cycle, one pc_we pulse, then FETCH.
  - rf_we = 1 for every class except BR and ST.
  - wb_sel = 1 for LD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel = 1 for JAL, 2 for JALR, (taken ? 1 : 0) for BR, 0 otherwise.
  - instret increments by 1 and wraps at 2^CNT_W.
  - imm_sel, alu_a_sel and alu_b_sel hold their EXEC values through MEM and WB so address and target stay stable.
- Timeout:
  - The counter clears on entering FETCH or MEM and increments each cycle the request is not accepted.
  - Reaching TIMEOUT with ready still low goes to HALT with cause 2 (FETCH) or 3 (MEM).
  - Ready arriving on the same cycle the counter hits TIMEOUT completes normally; ready wins.
- HALT: all strobes 0, trap = 1, trap_cause held; exits only via reset.
- Minimum latency: 4 cycles for non-memory instructions and 5 for LD/ST, with ready high on request.

Test Plan:
- Reset, then ADDI (op 0010011) with imem_ready tied 1 → imem_req/ir_we cycle 1; EXEC imm_sel = 1, b = 1; WB at cycle 4 with rf_we = pc_we = 1, pc_sel = 0; instret = 1.
- LW with dmem_ready low for 3 cycles → dmem_req high 4 cycles, dmem_we = 0; WB wb_sel = 1, rf_we = 1; total 8 cycles.
- BEQ with branch_taken = 1, then again with 0 → WB pc_sel = 1 then 0; rf_we = 0 both times; imm_sel = 3.
- JALR → imm_sel = 1, WB pc_sel = 2, wb_sel = 2, rf_we = 1.
- op = 1111111 → HALT after DECODE, trap = 1, trap_cause = 1, no further imem_req until rst_n pulse.
- TIMEOUT = 4 with imem_ready held 0 → HALT with cause 2 after 4 waiting cycles. Separately, assert rst_n low mid-MEM → all outputs 0 immediately, FETCH on release, instret = 0.
